// File: rtl/game_timer.sv
// -----------------------------------------------------------------------------
// game_timer
// Countdown timer for a game clock, kept in BCD as M:ST.SU.T (0:00.0 - 9:59.9).
// The count decrements by a tenth on each tick while running. Bonus time can
// be added while running or paused, and the sum saturates at 9:59.9.
//
// Ports
//   clk, resetN          system clock, asynchronous active-low reset
//   tick                 one-cycle pulse every 0.1 s
//   start/pause/load     one-cycle control pulses (priority load > pause > start)
//   add_time             one-cycle pulse, adds BONUS_SEC seconds
//   min_d/sec_t/sec_u/tenth   registered BCD digits
//   running, expired     state flags
//   timeout_pulse        one cycle on entry to EXPIRED
//   warning              RUN/PAUSE with fewer than WARN_SEC whole seconds left
//
// state   | meaning
// IDLE    | start value loaded, waiting for start
// RUN     | counting down on tick
// PAUSE   | frozen, bonus time still accepted
// EXPIRED | reached 0:00.0, holds until load
// -----------------------------------------------------------------------------
module game_timer #(
    parameter int START_MIN = 2,
    parameter int START_SEC = 0,
    parameter int BONUS_SEC = 5,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic       add_time,
    output logic [3:0] min_d,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] tenth,
    output logic       running,
    output logic       expired,
    output logic       timeout_pulse,
    output logic       warning
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam logic [15:0] START_BCD = {4'(START_MIN), 4'(START_SEC / 10),
                                         4'(START_SEC % 10), 4'd0};
    localparam logic [13:0] MAX_TENTHS   = 14'd5999;
    localparam logic [13:0] BONUS_TENTHS = 14'(BONUS_SEC * 10);

    state_t      state;
    logic [13:0] cur_tenths;
    logic [13:0] run_sum;
    logic [13:0] run_next;
    logic [13:0] pause_sum;
    logic [13:0] pause_next;

    // Arithmetic is done on a binary tenths count; the digits stay in BCD.
    function automatic logic [13:0] to_tenths(input logic [3:0] m, input logic [3:0] st,
                                              input logic [3:0] su, input logic [3:0] t);
        return 14'(m) * 14'd600 + 14'(st) * 14'd100 + 14'(su) * 14'd10 + 14'(t);
    endfunction

    function automatic logic [15:0] to_bcd(input logic [13:0] v);
        logic [13:0] r;
        logic [3:0]  m, st, su, t;
        m  = 4'(v / 14'd600);
        r  = v % 14'd600;
        st = 4'(r / 14'd100);
        r  = r % 14'd100;
        su = 4'(r / 14'd10);
        t  = 4'(r % 14'd10);
        return {m, st, su, t};
    endfunction

    assign cur_tenths = to_tenths(min_d, sec_t, sec_u, tenth);

    // In RUN the value is at least 0:00.1, so the tick borrow cannot underflow.
    always_comb begin
        run_sum    = cur_tenths + (add_time ? BONUS_TENTHS : 14'd0) - (tick ? 14'd1 : 14'd0);
        run_next   = (run_sum > MAX_TENTHS) ? MAX_TENTHS : run_sum;
        pause_sum  = cur_tenths + BONUS_TENTHS;
        pause_next = (pause_sum > MAX_TENTHS) ? MAX_TENTHS : pause_sum;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                         <= IDLE;
            {min_d, sec_t, sec_u, tenth}  <= START_BCD;
            timeout_pulse                 <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            if (load) begin
                state                        <= IDLE;
                {min_d, sec_t, sec_u, tenth} <= START_BCD;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cur_tenths == 14'd0) begin
                                state         <= EXPIRED;
                                timeout_pulse <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state <= PAUSE;
                        end else if (tick || add_time) begin
                            {min_d, sec_t, sec_u, tenth} <= to_bcd(run_next);
                            if (run_next == 14'd0) begin
                                state         <= EXPIRED;
                                timeout_pulse <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!pause) begin
                            if (start) begin
                                state <= RUN;
                            end else if (add_time) begin
                                {min_d, sec_t, sec_u, tenth} <= to_bcd(pause_next);
                            end
                        end
                    end
                    EXPIRED: begin
                        state <= EXPIRED;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);
    // Tenths are deliberately ignored: 0:09.9 warns, 0:10.0 does not.
    assign warning = ((state == RUN) || (state == PAUSE)) && (min_d == 4'd0) &&
                     (({4'd0, sec_t} * 8'd10 + {4'd0, sec_u}) < 8'(WARN_SEC));

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic tick = 1'b0, start = 1'b0, pause = 1'b0, load = 1'b0, add_time = 1'b0;

    logic [3:0] md[5], st[5], su[5], tn[5];
    logic       run[5], expd[5], tp[5], wrn[5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 0: default 2:00.0   1: 0:01.0   2: 9:58.0   3: 0:12.0   4: 0:00.0
    game_timer #(.START_MIN(2), .START_SEC(0)) dut0 (.clk(clk), .resetN(resetN), .tick(tick),
        .start(start), .pause(pause), .load(load), .add_time(add_time), .min_d(md[0]), .sec_t(st[0]),
        .sec_u(su[0]), .tenth(tn[0]), .running(run[0]), .expired(expd[0]), .timeout_pulse(tp[0]),
        .warning(wrn[0]));
    game_timer #(.START_MIN(0), .START_SEC(1)) dut1 (.clk(clk), .resetN(resetN), .tick(tick),
        .start(start), .pause(pause), .load(load), .add_time(add_time), .min_d(md[1]), .sec_t(st[1]),
        .sec_u(su[1]), .tenth(tn[1]), .running(run[1]), .expired(expd[1]), .timeout_pulse(tp[1]),
        .warning(wrn[1]));
    game_timer #(.START_MIN(9), .START_SEC(58)) dut2 (.clk(clk), .resetN(resetN), .tick(tick),
        .start(start), .pause(pause), .load(load), .add_time(add_time), .min_d(md[2]), .sec_t(st[2]),
        .sec_u(su[2]), .tenth(tn[2]), .running(run[2]), .expired(expd[2]), .timeout_pulse(tp[2]),
        .warning(wrn[2]));
    game_timer #(.START_MIN(0), .START_SEC(12)) dut3 (.clk(clk), .resetN(resetN), .tick(tick),
        .start(start), .pause(pause), .load(load), .add_time(add_time), .min_d(md[3]), .sec_t(st[3]),
        .sec_u(su[3]), .tenth(tn[3]), .running(run[3]), .expired(expd[3]), .timeout_pulse(tp[3]),
        .warning(wrn[3]));
    game_timer #(.START_MIN(0), .START_SEC(0)) dut4 (.clk(clk), .resetN(resetN), .tick(tick),
        .start(start), .pause(pause), .load(load), .add_time(add_time), .min_d(md[4]), .sec_t(st[4]),
        .sec_u(su[4]), .tenth(tn[4]), .running(run[4]), .expired(expd[4]), .timeout_pulse(tp[4]),
        .warning(wrn[4]));

    function automatic logic [15:0] dig(input int i);
        return {md[i], st[i], su[i], tn[i]};
    endfunction

    // Flags packed as {running, expired, timeout_pulse, warning}.
    function automatic logic [3:0] flg(input int i);
        return {run[i], expd[i], tp[i], wrn[i]};
    endfunction

    // Drive one cycle of inputs at a falling edge; return at the next falling
    // edge with inputs cleared, so the registered result is observable.
    task automatic drive(input logic t, input logic s, input logic p, input logic l, input logic a);
        @(negedge clk);
        tick = t; start = s; pause = p; load = l; add_time = a;
        @(negedge clk);
        tick = 0; start = 0; pause = 0; load = 0; add_time = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        resetN = 0;
        repeat (3) @(negedge clk);
        resetN = 1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if (dig(0) !== 16'h2000) begin errors++; $display("FAIL reset_digits got %h want 2000", dig(0)); end
        checks++;
        if (flg(0) !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flg(0)); end
        checks++;
        if (dig(1) !== 16'h0010) begin errors++; $display("FAIL reset_digits_b got %h want 0010", dig(1)); end
    endtask

    task automatic test_countdown;
        apply_reset();
        drive(0, 1, 0, 0, 0);
        checks++;
        if (flg(0) !== 4'b1000) begin errors++; $display("FAIL start_flags got %b want 1000", flg(0)); end
        ticks(1);
        checks++;
        if (dig(0) !== 16'h1599) begin errors++; $display("FAIL borrow_chain got %h want 1599", dig(0)); end
        ticks(9);
        checks++;
        if (dig(0) !== 16'h1590 || flg(0) !== 4'b1000) begin
            errors++; $display("FAIL ten_ticks got %h/%b want 1590/1000", dig(0), flg(0));
        end
        drive(0, 0, 0, 0, 1);
        checks++;
        if (dig(0) !== 16'h2040) begin errors++; $display("FAIL add_run_carry got %h want 2040", dig(0)); end
        drive(0, 0, 1, 0, 0);
        ticks(1);
        checks++;
        if (dig(0) !== 16'h2040 || run[0] !== 1'b0) begin
            errors++; $display("FAIL pause_tick got %h run %b want 2040 run 0", dig(0), run[0]);
        end
        drive(0, 1, 0, 0, 0);
        ticks(1);
        checks++;
        if (dig(0) !== 16'h2039 || run[0] !== 1'b1) begin
            errors++; $display("FAIL resume got %h run %b want 2039 run 1", dig(0), run[0]);
        end
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        ticks(1);
        checks++;
        if (dig(0) !== 16'h2000 || flg(0) !== 4'b0000) begin
            errors++; $display("FAIL idle_ignores got %h/%b want 2000/0000", dig(0), flg(0));
        end
    endtask

    task automatic test_expire;
        apply_reset();
        drive(0, 1, 0, 0, 0);
        checks++;
        if (flg(4) !== 4'b0110 || dig(4) !== 16'h0000) begin
            errors++; $display("FAIL zero_start got %h/%b want 0000/0110", dig(4), flg(4));
        end
        ticks(9);
        checks++;
        if (dig(1) !== 16'h0001 || expd[1] !== 1'b0) begin
            errors++; $display("FAIL pre_expire got %h exp %b want 0001 exp 0", dig(1), expd[1]);
        end
        ticks(1);
        checks++;
        if (dig(1) !== 16'h0000 || flg(1) !== 4'b0110) begin
            errors++; $display("FAIL expire got %h/%b want 0000/0110", dig(1), flg(1));
        end
        @(negedge clk);
        checks++;
        if (tp[1] !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", tp[1]); end
        ticks(2);
        drive(0, 1, 0, 0, 0);
        checks++;
        if (dig(1) !== 16'h0000 || flg(1) !== 4'b0100) begin
            errors++; $display("FAIL expired_hold got %h/%b want 0000/0100", dig(1), flg(1));
        end
        drive(0, 0, 0, 1, 0);
        checks++;
        if (dig(1) !== 16'h0010 || flg(1) !== 4'b0000) begin
            errors++; $display("FAIL load_expired got %h/%b want 0010/0000", dig(1), flg(1));
        end
    endtask

    task automatic test_warning;
        apply_reset();
        drive(0, 1, 0, 0, 0);
        ticks(20);
        checks++;
        if (dig(3) !== 16'h0100 || wrn[3] !== 1'b0) begin
            errors++; $display("FAIL warn_edge got %h w %b want 0100 w 0", dig(3), wrn[3]);
        end
        ticks(1);
        checks++;
        if (dig(3) !== 16'h0099 || wrn[3] !== 1'b1) begin
            errors++; $display("FAIL warn_rise got %h w %b want 0099 w 1", dig(3), wrn[3]);
        end
        drive(0, 0, 1, 0, 0);
        checks++;
        if (wrn[3] !== 1'b1 || run[3] !== 1'b0) begin
            errors++; $display("FAIL warn_pause got w %b run %b want w 1 run 0", wrn[3], run[3]);
        end
        drive(0, 0, 0, 1, 0);
        checks++;
        if (dig(3) !== 16'h0120 || wrn[3] !== 1'b0) begin
            errors++; $display("FAIL warn_load got %h w %b want 0120 w 0", dig(3), wrn[3]);
        end
    endtask

    task automatic test_saturate;
        apply_reset();
        drive(0, 1, 0, 0, 0);
        ticks(7);
        checks++;
        if (dig(2) !== 16'h9573) begin errors++; $display("FAIL sat_setup got %h want 9573", dig(2)); end
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        checks++;
        if (dig(2) !== 16'h9599 || run[2] !== 1'b0) begin
            errors++; $display("FAIL saturate got %h run %b want 9599 run 0", dig(2), run[2]);
        end
        ticks(1);
        checks++;
        if (dig(2) !== 16'h9599) begin errors++; $display("FAIL pause_tick_sat got %h want 9599", dig(2)); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        drive(0, 1, 0, 0, 0);
        ticks(119);
        checks++;
        if (dig(3) !== 16'h0001) begin errors++; $display("FAIL b2b_setup got %h want 0001", dig(3)); end
        drive(1, 0, 0, 0, 1);
        checks++;
        if (dig(3) !== 16'h0050 || flg(3) !== 4'b1001) begin
            errors++; $display("FAIL tick_add got %h/%b want 0050/1001", dig(3), flg(3));
        end
        drive(0, 1, 1, 0, 0);
        checks++;
        if (run[3] !== 1'b0 || dig(3) !== 16'h0050) begin
            errors++; $display("FAIL start_pause got run %b %h want run 0 0050", run[3], dig(3));
        end
        drive(0, 1, 1, 0, 0);
        checks++;
        if (run[3] !== 1'b0) begin errors++; $display("FAIL pause_stays got run %b want 0", run[3]); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        drive(0, 1, 0, 0, 0);
        ticks(296);
        checks++;
        if (dig(0) !== 16'h1304) begin errors++; $display("FAIL mid_setup got %h want 1304", dig(0)); end
        @(negedge clk);
        resetN = 0;
        #1;
        checks++;
        if (dig(0) !== 16'h2000 || flg(0) !== 4'b0000) begin
            errors++; $display("FAIL async_reset got %h/%b want 2000/0000", dig(0), flg(0));
        end
        repeat (3) @(negedge clk);
        resetN = 1;
        @(negedge clk);
        checks++;
        if (dig(0) !== 16'h2000 || flg(0) !== 4'b0000) begin
            errors++; $display("FAIL post_reset got %h/%b want 2000/0000", dig(0), flg(0));
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_expire();
        test_warning();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter START_MIN, default 2, minutes digit loaded at reset and on load (0-9).
REQ-002 Parameter START_SEC, default 0, seconds loaded at reset and on load (0-59).
REQ-003 Parameter BONUS_SEC, default 5, seconds added per add_time pulse (1-59).
REQ-004 Parameter WARN_SEC, default 10, warning threshold in seconds (1-59).
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  reset, asynchronous, active-low.
REQ-007 tick  in  1  one-cycle pulse every 0.1 s from the tenth-second counter.
REQ-008 start  in  1  one-cycle pulse, begin or resume countdown.
REQ-009 pause  in  1  one-cycle pulse, freeze countdown.
REQ-010 load  in  1  one-cycle pulse, reload start value and return to IDLE.
REQ-011 add_time  in  1  one-cycle pulse, add BONUS_SEC seconds.
REQ-012 min_d  out  4  BCD minutes (0-9).
REQ-013 sec_t  out  4  BCD seconds tens (0-5).
REQ-014 sec_u  out  4  BCD seconds units (0-9).
REQ-015 tenth  out  4  BCD tenths (0-9).
REQ-016 running  out  1  high while in RUN.
REQ-017 expired  out  1  high while in EXPIRED.
REQ-018 timeout_pulse  out  1  one-cycle pulse on entering EXPIRED.
REQ-019 warning  out  1  high in RUN/PAUSE while remaining time < WARN_SEC s.

Function
REQ-020 The block SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-021 Input priority per cycle SHALL be: load > pause > start > add_time/tick.
REQ-022 load in any state SHALL set digits to START_MIN:START_SEC.0 and state IDLE next cycle; tick/add_time that cycle ignored.
REQ-023 start in IDLE or PAUSE SHALL enter RUN next cycle; start in RUN or EXPIRED is ignored.
REQ-024 pause in RUN SHALL enter PAUSE; pause elsewhere ignored; pause and start same cycle -> pause wins (RUN->PAUSE, PAUSE stays).
REQ-025 tick in RUN SHALL decrement the value by 0.1 s, digits registered, visible the cycle after tick is sampled.
REQ-026 Decrement borrow chain: tenth 0->9 borrows sec_u; sec_u 0->9 borrows sec_t; sec_t 0->5 borrows min_d.
REQ-027 tick outside RUN SHALL leave digits unchanged.
REQ-028 A tick in RUN producing 0:00.0 SHALL enter EXPIRED in the same update; timeout_pulse high exactly that one cycle.
REQ-029 start in IDLE with value 0:00.0 SHALL go directly to EXPIRED with timeout_pulse.
REQ-030 add_time in RUN or PAUSE SHALL add BONUS_SEC s with BCD carries (sec_u>9, sec_t>5 carry upward); ignored in IDLE/EXPIRED.
REQ-031 Sum above 9:59.9 SHALL saturate to 9:59.9.
REQ-032 tick and add_time same cycle in RUN: result SHALL be value - 0.1 s + BONUS_SEC s, then saturated; no expiry if result > 0.
REQ-033 EXPIRED SHALL hold digits at 0:00.0 until load.
REQ-034 warning SHALL equal (state RUN or PAUSE) and min_d==0 and (10*sec_t+sec_u) < WARN_SEC, derived from registered state.
REQ-035 All outputs SHALL be driven from registers or registered state only; no input-to-output combinational path.

Reset
REQ-036 On resetN low: state IDLE, digits START_MIN:START_SEC.0, running/expired/timeout_pulse/warning 0.
REQ-037 Reset mid-countdown SHALL abandon the count immediately; first cycle after release is IDLE, no timeout_pulse.

Verification
REQ-038 Defaults, start, 10 ticks -> digits 1:59.0, running=1, warning=0.
REQ-039 START_MIN=0, START_SEC=1, start, 10 ticks -> 10th tick gives 0:00.0, expired=1, timeout_pulse exactly 1 cycle, further ticks no change.
REQ-040 Value 0:12.0 in RUN, 21 ticks -> 0:09.9, warning rises on the update reaching 0:09.9.
REQ-041 Value 9:57.3 in PAUSE, add_time -> 9:59.9 (saturate), state stays PAUSE; tick ignored.
REQ-042 Value 0:00.1 in RUN, tick+add_time same cycle -> 0:05.0, no timeout_pulse; then start+pause same cycle -> PAUSE.
REQ-043 Mid-RUN at 1:30.4 assert resetN low 3 cycles -> 2:00.0 IDLE, all flags 0; load in EXPIRED -> 2:00.0 IDLE.
